// File: rtl/seq_add16_ctrl.sv
// -----------------------------------------------------------------------------
// seq_add16_ctrl
//
// Purpose:
//   Multi-cycle adder. One 4-bit carry-lookahead slice (cla4bit) is reused once
//   per nibble, least-significant nibble first. The carry out of each nibble is
//   registered and fed back into the slice on the next cycle.
//   A full W-bit addition takes NIB cycles in RUN followed by one DONE cycle.
//   The done pulse appears on the edge that leaves DONE, so a new start can be
//   accepted in DONE without a gap.
//
// Ports:
//   clk    in   1  single clock, rising edge
//   rst_n  in   1  asynchronous active-low reset
//   start  in   1  begin one addition (honoured in IDLE and DONE only)
//   a, b   in   W  operands, captured when start is accepted
//   cin    in   1  carry-in, captured when start is accepted
//   busy   out  1  high exactly while the FSM is in RUN
//   done   out  1  one-cycle pulse: sum/cout/ovf hold a new result
//   sum    out  W  registered result, modulo 2^W
//   cout   out  1  registered carry out of bit W-1
//   ovf    out  1  registered two's-complement overflow
// -----------------------------------------------------------------------------

// -----------------------------------------------------------------------------
// cla4bit
//
// Purpose:
//   Purely combinational 4-bit carry-lookahead adder slice.
//
// Ports:
//   a, b   in   4  nibble operands
//   ci     in   1  carry into bit 0
//   s      out  4  sum nibble
//   c3     out  1  carry into bit 3 (used for the overflow flag)
//   c4     out  1  carry out of bit 3
// -----------------------------------------------------------------------------
module cla4bit (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       ci,
  output logic [3:0] s,
  output logic       c3,
  output logic       c4
);

  logic [3:0] g;
  logic [3:0] p;
  logic [4:0] c;

  assign g = a & b;
  assign p = a ^ b;

  // Every carry is expanded directly from generate/propagate terms, so no
  // carry depends on the previous one.
  assign c[0] = ci;
  assign c[1] = g[0] | (p[0] & ci);
  assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & ci);
  assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
              | (p[2] & p[1] & p[0] & ci);
  assign c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
              | (p[3] & p[2] & p[1] & g[0])
              | (p[3] & p[2] & p[1] & p[0] & ci);

  assign s  = p ^ c[3:0];
  assign c3 = c[3];
  assign c4 = c[4];

endmodule

module seq_add16_ctrl #(
  parameter int NIB = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [4*NIB-1:0] a,
  input  logic [4*NIB-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [4*NIB-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int W  = 4 * NIB;
  localparam int CW = (NIB > 1) ? $clog2(NIB) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(NIB - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q,   cnt_d;
  logic            carry_q, carry_d;
  logic [W-1:0]    a_w_q,   a_w_d;
  logic [W-1:0]    b_w_q,   b_w_d;
  logic [W-1:0]    ws_q,    ws_d;
  logic [W-1:0]    sum_q,   sum_d;
  logic            cout_q,  cout_d;
  logic            ovf_q,   ovf_d;
  logic            busy_q,  busy_d;
  logic            done_q,  done_d;

  // ---------------------------------------------------------------------------
  // Nibble selection for the shared slice
  // ---------------------------------------------------------------------------
  logic [3:0] a_nib [NIB];
  logic [3:0] b_nib [NIB];

  genvar gi;
  for (gi = 0; gi < NIB; gi++) begin : g_nib
    assign a_nib[gi] = a_w_q[4*gi +: 4];
    assign b_nib[gi] = b_w_q[4*gi +: 4];
  end

  logic [3:0] slice_a;
  logic [3:0] slice_b;
  logic [3:0] slice_s;
  logic       slice_c3;
  logic       slice_c4;

  // cnt never exceeds NIB-1, so the index is always in range.
  assign slice_a = a_nib[cnt_q];
  assign slice_b = b_nib[cnt_q];

  cla4bit u_cla (
    .a  (slice_a),
    .b  (slice_b),
    .ci (carry_q),
    .s  (slice_s),
    .c3 (slice_c3),
    .c4 (slice_c4)
  );

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    carry_d = carry_q;
    a_w_d   = a_w_q;
    b_w_d   = b_w_q;
    ws_d    = ws_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;

    case (state_q)
      // DONE accepts start exactly like IDLE, which gives back-to-back
      // operation at one result per NIB+1 cycles.
      IDLE, DONE: begin
        if (start) begin
          a_w_d   = a;
          b_w_d   = b;
          carry_d = cin;
          cnt_d   = '0;
          ws_d    = '0;
          state_d = RUN;
        end else begin
          state_d = IDLE;
        end
      end

      RUN: begin
        for (int i = 0; i < NIB; i++) begin
          if (cnt_q == CW'(i)) begin
            ws_d[4*i +: 4] = slice_s;
          end
        end
        carry_d = slice_c4;

        if (cnt_q == CNT_LAST) begin
          // ws_d already contains the final nibble written above.
          sum_d   = ws_d;
          cout_d  = slice_c4;
          // Carry into the MSB differs from carry out of it -> signed overflow.
          ovf_d   = slice_c4 ^ slice_c3;
          cnt_d   = '0;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d = (state_d == RUN);
    // done is the registered image of "was in DONE", so it rises on the edge
    // that leaves DONE: NIB+1 edges after the accepting edge.
    done_d = (state_q == DONE);
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      a_w_q   <= '0;
      b_w_q   <= '0;
      ws_q    <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      carry_q <= carry_d;
      a_w_q   <= a_w_d;
      b_w_q   <= b_w_d;
      ws_q    <= ws_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign sum  = sum_q;
  assign cout = cout_q;
  assign ovf  = ovf_q;

endmodule

// File: tb/tb_seq_add16_ctrl.sv
// -----------------------------------------------------------------------------
// tb_seq_add16_ctrl
//
// Purpose:
//   Self-checking bench for seq_add16_ctrl (NIB=4). Expected results come from
//   plain W+1-bit arithmetic; overflow from the operand/result sign rule.
//   Covers reset state, directed corner cases, ignored start during RUN,
//   back-to-back operation, asynchronous mid-RUN reset and random operands.
// -----------------------------------------------------------------------------
module tb_seq_add16_ctrl;

  localparam int NIB = 4;
  localparam int W   = 4 * NIB;
  localparam int LAT = NIB + 1;

  logic         clk   = 1'b0;
  logic         rst_n = 1'b1;
  logic         start = 1'b0;
  logic [W-1:0] a     = '0;
  logic [W-1:0] b     = '0;
  logic         cin   = 1'b0;
  logic         busy;
  logic         done;
  logic [W-1:0] sum;
  logic         cout;
  logic         ovf;

  always #5 clk = ~clk;

  seq_add16_ctrl #(.NIB(NIB)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .a     (a),
    .b     (b),
    .cin   (cin),
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .cout  (cout),
    .ovf   (ovf)
  );

  int n_checks = 0;
  int n_errors = 0;

  // Values the result outputs are expected to be holding right now.
  logic [W-1:0] hold_sum  = '0;
  logic         hold_cout = 1'b0;
  logic         hold_ovf  = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Reference: full-precision addition, overflow when both operands share a
  // sign and the wrapped result does not.
  task automatic model(input logic [W-1:0] x, input logic [W-1:0] y, input logic c,
                       output logic [W-1:0] s, output logic co, output logic ov);
    logic [W:0] full;
    full = {1'b0, x} + {1'b0, y} + {{W{1'b0}}, c};
    s    = full[W-1:0];
    co   = full[W];
    ov   = (x[W-1] == y[W-1]) && (s[W-1] != x[W-1]);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One complete addition. With disturb set, a/b/cin are scrambled and start
  // is randomly re-pulsed while the DUT is in RUN.
  task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb, input logic tc,
                        input bit disturb, input string name);
    logic [W-1:0] es;
    logic         ec;
    logic         eo;
    int           k;
    model(ta, tb, tc, es, ec, eo);
    a     = ta;
    b     = tb;
    cin   = tc;
    start = 1'b1;
    tick();
    start = 1'b0;
    k     = 0;
    while (done !== 1'b1 && k < 4 * LAT) begin
      check({name, ":busy"}, busy, (k < NIB));
      if (k < NIB) begin
        check({name, ":sum_hold"},  sum,  hold_sum);
        check({name, ":cout_hold"}, cout, hold_cout);
        check({name, ":ovf_hold"},  ovf,  hold_ovf);
      end
      if (disturb) begin
        a     = W'($urandom);
        b     = W'($urandom);
        cin   = 1'($urandom);
        start = (k < NIB) ? 1'($urandom) : 1'b0;
      end
      tick();
      k++;
    end
    start = 1'b0;
    check({name, ":latency"}, k, LAT);
    check({name, ":done"},    done, 1'b1);
    check({name, ":sum"},     sum,  es);
    check({name, ":cout"},    cout, ec);
    check({name, ":ovf"},     ovf,  eo);
    $display("op %s: a=%h b=%h cin=%b -> sum=%h cout=%b ovf=%b latency=%0d",
             name, ta, tb, tc, sum, cout, ovf, k);
    hold_sum  = es;
    hold_cout = ec;
    hold_ovf  = eo;
    tick();
    check({name, ":done_1cyc"}, done, 1'b0);
    check({name, ":busy_idle"}, busy, 1'b0);
  endtask

  task automatic check_all_zero(input string name);
    check({name, ":busy"}, busy, 1'b0);
    check({name, ":done"}, done, 1'b0);
    check({name, ":sum"},  sum,  '0);
    check({name, ":cout"}, cout, 1'b0);
    check({name, ":ovf"},  ovf,  1'b0);
  endtask

  initial begin
    logic [W-1:0] s1;
    logic [W-1:0] s2;
    logic         c1;
    logic         c2;
    logic         o1;
    logic         o2;

    // Asynchronous reset before any clock edge.
    #2 rst_n = 1'b0;
    #1 check_all_zero("reset");
    repeat (3) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    tick();
    check_all_zero("post_reset");

    // Directed corner cases.
    run_op(16'h000A, 16'h0005, 1'b1, 1'b0, "a_plus_b_cin");
    run_op(16'hFFFF, 16'h0001, 1'b0, 1'b0, "full_ripple");
    run_op(16'h7FFF, 16'h0001, 1'b0, 1'b0, "pos_ovf");
    run_op(16'h8000, 16'h8000, 1'b0, 1'b0, "neg_ovf");
    run_op(16'h4321, 16'h1234, 1'b0, 1'b1, "start_in_run");

    // Back-to-back: start held high, new operands presented in DONE.
    model(16'h1234, 16'h1111, 1'b0, s1, c1, o1);
    model(16'h0001, 16'h0001, 1'b0, s2, c2, o2);
    a     = 16'h1234;
    b     = 16'h1111;
    cin   = 1'b0;
    start = 1'b1;
    tick();
    for (int k = 0; k <= 2 * LAT; k++) begin
      check("b2b:done", done, (k == LAT || k == 2 * LAT));
      check("b2b:busy", busy, (k < 2 * LAT && (k % LAT) != NIB));
      if (k == LAT) begin
        check("b2b:sum1", sum, s1);
        check("b2b:cout1", cout, c1);
        $display("op b2b1: a=1234 b=1111 cin=0 -> sum=%h cout=%b ovf=%b", sum, cout, ovf);
      end
      if (k == 2 * LAT) begin
        check("b2b:sum2", sum, s2);
        check("b2b:ovf2", ovf, o2);
        $display("op b2b2: a=0001 b=0001 cin=0 -> sum=%h cout=%b ovf=%b", sum, cout, ovf);
      end
      if (k == NIB) begin
        a = 16'h0001;
        b = 16'h0001;
      end
      if (k == LAT + NIB) begin
        start = 1'b0;
      end
      if (k < 2 * LAT) begin
        tick();
      end
    end
    hold_sum  = s2;
    hold_cout = c2;
    hold_ovf  = o2;
    tick();
    check("b2b:done_end", done, 1'b0);

    // Asynchronous reset in the middle of RUN.
    a     = 16'hABCD;
    b     = 16'h1357;
    cin   = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    check("mid_rst:busy_before", busy, 1'b1);
    #3 rst_n = 1'b0;
    #1 check_all_zero("mid_rst");
    $display("op mid_rst: reset asserted during RUN, outputs cleared");
    hold_sum  = '0;
    hold_cout = 1'b0;
    hold_ovf  = 1'b0;
    repeat (2) tick();
    check_all_zero("mid_rst_held");
    @(negedge clk) rst_n = 1'b1;
    tick();
    check("mid_rst:no_done", done, 1'b0);
    run_op(16'h0003, 16'h0004, 1'b0, 1'b0, "after_rst");

    // Random operands, some with start re-pulsed / inputs scrambled in RUN.
    for (int i = 0; i < 40; i++) begin
      run_op(W'($urandom), W'($urandom), 1'($urandom), bit'($urandom_range(0, 1)), "rand");
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  // Absolute time limit so the bench can never hang.
  initial begin
    #200000;
    $display("FAIL timeout: got 0x0 expected 0x1 (simulation did not complete)");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/seq_add16_ctrl.md
SEQ_ADD16_CTRL -- requirements
Module: seq_add16_ctrl

Interface
REQ-001 SHALL have parameter NIB, default 4, meaning number of 4-bit nibbles processed; operand width W = 4*NIB.
REQ-002 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-004 SHALL have port start, input, 1, request to begin one addition.
REQ-005 SHALL have port a, input, W, operand A, sampled only when start is accepted.
REQ-006 SHALL have port b, input, W, operand B, sampled only when start is accepted.
REQ-007 SHALL have port cin, input, 1, carry-in, sampled only when start is accepted.
REQ-008 SHALL have port busy, output, 1, high while an addition is in progress.
REQ-009 SHALL have port done, output, 1, one-cycle pulse marking a new valid result.
REQ-010 SHALL have port sum, output, W, registered result.
REQ-011 SHALL have port cout, output, 1, registered carry-out of the MSB.
REQ-012 SHALL have port ovf, output, 1, registered two's-complement overflow flag.

Function
REQ-013 SHALL instantiate one CLA4bit slice and reuse it once per nibble, LSB nibble first; the sum nibble is s[3:0] and the nibble carry-out is c[4].
REQ-014 SHALL implement FSM states IDLE, RUN and DONE.
REQ-015 IDLE: start=1 SHALL latch a, b and cin into working registers, clear nibble counter cnt to 0, load carry register with cin, and go to RUN.
REQ-016 RUN: each cycle SHALL drive the slice with nibble cnt of the latched a/b and the carry register, write s[3:0] into working-sum nibble cnt, load carry with c[4], and increment cnt.
REQ-017 RUN with cnt==NIB-1 SHALL load sum from the completed working sum, cout from c[4], and ovf from c[4] XOR c[3] of that final slice, then go to DONE.
REQ-018 DONE SHALL assert done for exactly one cycle, then go to IDLE; start=1 in DONE SHALL be accepted exactly as in IDLE (back-to-back).
REQ-019 Latency: done SHALL be high in the cycle beginning NIB+1 rising edges after the edge that accepted start (5 for NIB=4); throughput is one result per NIB+1 cycles.
REQ-020 busy SHALL be 1 exactly in RUN; start while busy=1 SHALL be ignored, and a/b/cin changes during RUN SHALL not affect the result.
REQ-021 sum, cout and ovf SHALL hold their last value until the next REQ-017 update; they SHALL not change during RUN.
REQ-022 cnt SHALL be ceil(log2(NIB)) bits wide (minimum 1) and SHALL never exceed NIB-1.
REQ-023 Full-width wrap: results SHALL be modulo 2^W, with the carry out of bit W-1 reported only on cout.

Reset
REQ-024 rst_n=0 SHALL immediately, regardless of clk, force state IDLE, cnt=0, carry=0, working registers=0, busy=0, done=0, sum=0, cout=0, ovf=0.
REQ-025 Reset asserted mid-RUN SHALL abort the operation with no done pulse and no update of the result outputs other than clearing them.
REQ-026 After rst_n deasserts, the first rising edge with start=1 SHALL be accepted normally.

Verification
REQ-027 a=0x000A, b=0x0005, cin=1, start pulsed -> busy high for 4 cycles, done pulse 5 edges later, sum=0x0010, cout=0, ovf=0.
REQ-028 a=0xFFFF, b=0x0001, cin=0 -> sum=0x0000, cout=1, ovf=0 (full carry ripple across all nibbles).
REQ-029 a=0x7FFF, b=0x0001, cin=0 -> sum=0x8000, cout=0, ovf=1; then a=0x8000, b=0x8000 -> sum=0x0000, cout=1, ovf=1.
REQ-030 start re-pulsed with new operands during RUN -> ignored; result matches the first operands, a single done pulse.
REQ-031 start held high continuously with 0x1234+0x1111, then 0x0001+0x0001 applied in the DONE cycle -> done pulses 5 cycles apart, sums 0x2345 then 0x0002.
REQ-032 rst_n pulsed low mid-RUN (asynchronous to clk) -> all outputs 0 immediately, no done pulse; next start of 0x0003+0x0004 gives sum=0x0007.
